// File: rtl/hb_pkg.sv
// Shared definitions for the boot copier: FSM state encoding and default widths.
package hb_pkg;

  localparam int HB_DATA_W = 8;
  localparam int HB_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } bl_state_t;

endpackage

// File: rtl/hb_boot_counter.sv
// Word index counter plus ROM latency sub-counter for the boot copier.
module hb_boot_counter
  import hb_pkg::*;
#(
  parameter int ADDR_W  = HB_ADDR_W,
  parameter int LEN     = 4096,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idx_clr_i,
  input  logic              idx_inc_i,
  input  logic              lat_clr_i,
  input  logic              lat_inc_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic [ADDR_W-1:0] idx_next_o,
  output logic              idx_last_o,
  output logic              lat_last_o
);

  // Terminal index is LEN-1, so LEN = 2**ADDR_W stops on all-ones rather than on wrap.
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(LEN - 1);
  localparam logic [1:0]        LAT_LAST = 2'(ROM_LAT - 1);

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        lat_q, lat_d;

  always_comb begin
    idx_d = idx_q;
    if (idx_clr_i) begin
      idx_d = '0;
    end else if (idx_inc_i) begin
      idx_d = idx_q + ADDR_W'(1);
    end
  end

  always_comb begin
    lat_d = lat_q;
    if (lat_clr_i) begin
      lat_d = 2'd0;
    end else if (lat_inc_i) begin
      lat_d = lat_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      lat_q <= 2'd0;
    end else begin
      idx_q <= idx_d;
      lat_q <= lat_d;
    end
  end

  assign idx_o      = idx_q;
  assign idx_next_o = idx_d;
  assign idx_last_o = (idx_q == IDX_LAST);
  assign lat_last_o = (lat_q == LAT_LAST);

endmodule

// File: rtl/boot_copier.sv
// Boot copier: moves LEN words from ROM to RAM at RAM_BASE, keeps a running
// checksum of accepted words and raises done to release the CPU.
module boot_copier
  import hb_pkg::*;
#(
  parameter int DATA_W    = HB_DATA_W,
  parameter int ADDR_W    = HB_ADDR_W,
  parameter int LEN       = 4096,
  parameter int RAM_BASE  = 0,
  parameter int ROM_LAT   = 1,
  parameter int AUTO_BOOT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic              ram_ready,
  output logic              active,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(RAM_BASE);

  bl_state_t         state_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              rom_rd_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_we_q;
  logic              active_q;
  logic              done_q;
  logic [DATA_W-1:0] checksum_q;

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;
  logic              idx_last;
  logic              lat_last;
  logic              idx_clr;
  logic              idx_inc;
  logic              accept;

  assign accept  = (state_q == WRITE) && ram_ready;
  assign idx_clr = (state_q == DONE) && start;
  assign idx_inc = accept && !idx_last;

  hb_boot_counter #(
    .ADDR_W (ADDR_W),
    .LEN    (LEN),
    .ROM_LAT(ROM_LAT)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .idx_clr_i (idx_clr),
    .idx_inc_i (idx_inc),
    .lat_clr_i (state_q == READ),
    .lat_inc_i (state_q == WAIT),
    .idx_o     (idx),
    .idx_next_o(idx_next),
    .idx_last_o(idx_last),
    .lat_last_o(lat_last)
  );

  // Every entry into READ loads rom_addr from the counter's next value, so the
  // address lines up with the index the counter holds during that READ cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      rom_rd_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((AUTO_BOOT != 0) || start) begin
            state_q    <= READ;
            rom_rd_q   <= 1'b1;
            rom_addr_q <= idx_next;
            active_q   <= 1'b1;
          end
        end
        READ: begin
          state_q  <= WAIT;
          rom_rd_q <= 1'b0;
        end
        WAIT: begin
          if (lat_last) begin
            state_q     <= WRITE;
            ram_wdata_q <= rom_data;
            ram_addr_q  <= BASE + idx;
            ram_we_q    <= 1'b1;
          end
        end
        WRITE: begin
          if (ram_ready) begin
            ram_we_q   <= 1'b0;
            checksum_q <= checksum_q + ram_wdata_q;
            if (idx_last) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              active_q <= 1'b0;
            end else begin
              state_q    <= READ;
              rom_rd_q   <= 1'b1;
              rom_addr_q <= idx_next;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_q    <= READ;
            done_q     <= 1'b0;
            active_q   <= 1'b1;
            rom_rd_q   <= 1'b1;
            rom_addr_q <= idx_next;
            checksum_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_rd    = rom_rd_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign active    = active_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_boot_copier.sv
// Scoreboard bench for boot_copier: four configurations run side by side.
module tb_boot_copier;

  // Instances: 0 defaults, 1 wrap/stall/manual start, 2 reset abort, 3 single word.
  function automatic int len_of(input int k);
    case (k)
      0: return 4096;
      1: return 4;
      2: return 8;
      default: return 1;
    endcase
  endfunction
  function automatic int base_of(input int k);
    return (k == 1) ? 32'hFFE : 0;
  endfunction
  function automatic int lat_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction
  function automatic int auto_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction
  function automatic logic [7:0] rom_val(input int k, input logic [11:0] a);
    case (k)
      0: return a[7:0];
      1: return 8'(({6'd0, a[1:0]} + 8'd1) * 8'h11);
      2: return 8'h80 + a[7:0];
      default: return 8'h5A;
    endcase
  endfunction

  localparam logic [63:0] M_OUTS    = 64'h0000_0FFF_FFFF_FFFF;
  localparam logic [63:0] M_RD      = 64'hFFFF_0000_0000_0000;
  localparam logic [63:0] M_NOAUTO  = 64'hFFFF_0300_0000_0000;
  localparam logic [63:0] M_RESTART = 64'h0000_0FFF_F000_00FF;
  localparam logic [63:0] V_RESTART = 64'h0000_0A00_0000_0000;
  localparam logic [63:0] M_RDADDR  = 64'h0000_08FF_F000_0000;
  localparam logic [63:0] V_RDADDR0 = 64'h0000_0800_0000_0000;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;
  typedef struct {
    int         cyc;
    logic [7:0] ck;
  } dn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v     [4];
  logic        start_v   [4];
  logic [11:0] rom_addr  [4];
  logic        rom_rd    [4];
  logic [7:0]  rom_data  [4];
  logic [11:0] ram_addr  [4];
  logic [7:0]  ram_wdata [4];
  logic        ram_we    [4];
  logic        ram_ready [4];
  logic        active    [4];
  logic        done      [4];
  logic [7:0]  checksum  [4];

  wr_t exp_wr [4][$];
  dn_t exp_dn [4][$];

  int rel_cyc [4];
  int rd_cnt  [4];
  int fin_rd  [4];
  int stall_left = 2;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int tmo_cnt  = 0;

  logic        pr_req  = 1'b0;
  int          pr_k    = 0;
  logic [63:0] pr_m    = '0;
  logic [63:0] pr_v    = '0;
  string       pr_nm   = "";
  logic        fin_req = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      logic [7:0] stg [4];

      // ROM model: data is valid only in the one cycle ROM_LAT after the strobe.
      always @(posedge clk) begin
        stg[0] <= rom_rd[gi] ? rom_val(gi, rom_addr[gi]) : 8'hEE;
        for (int j = 1; j < 4; j++) stg[j] <= stg[j-1];
      end
      assign rom_data[gi]  = stg[lat_of(gi)-1];
      assign ram_ready[gi] = (gi == 1) ?
          !(ram_we[gi] && ram_addr[gi] == 12'hFFF && stall_left != 0) : 1'b1;

      always @(posedge clk) rel_cyc[gi] <= rst_v[gi] ? 0 : rel_cyc[gi] + 1;

      boot_copier #(
        .DATA_W   (8),
        .ADDR_W   (12),
        .LEN      (len_of(gi)),
        .RAM_BASE (base_of(gi)),
        .ROM_LAT  (lat_of(gi)),
        .AUTO_BOOT(auto_of(gi))
      ) u_dut (
        .clk      (clk),
        .rst      (rst_v[gi]),
        .start    (start_v[gi]),
        .rom_addr (rom_addr[gi]),
        .rom_rd   (rom_rd[gi]),
        .rom_data (rom_data[gi]),
        .ram_addr (ram_addr[gi]),
        .ram_wdata(ram_wdata[gi]),
        .ram_we   (ram_we[gi]),
        .ram_ready(ram_ready[gi]),
        .active   (active[gi]),
        .done     (done[gi]),
        .checksum (checksum[gi])
      );
    end
  endgenerate

  always @(posedge clk)
    if (ram_we[1] && !ram_ready[1] && stall_left > 0) stall_left <= stall_left - 1;

  function automatic void chk(input string nm, input int k,
                              input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", nm, k, act, req);
  endfunction

  function automatic logic [63:0] pack(input int k);
    return {rd_cnt[k][15:0], 4'b0, rom_rd[k], ram_we[k], active[k], done[k],
            rom_addr[k], ram_addr[k], ram_wdata[k], checksum[k]};
  endfunction

  // Monitor: the only process that compares and steps the check counters.
  logic        prev_stall [4];
  logic [11:0] prev_addr  [4];
  logic [7:0]  prev_data  [4];
  logic        done_prev  [4];
  initial for (int k = 0; k < 4; k++) begin
    prev_stall[k] = 1'b0;
    done_prev[k]  = 1'b0;
    rd_cnt[k]     = 0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      wr_t w;
      dn_t d;
      if (rom_rd[k]) rd_cnt[k]++;
      if (ram_we[k] && ram_ready[k]) begin
        if (exp_wr[k].size() == 0) begin
          chk("unexpected_write_addr", k, {52'd0, ram_addr[k]}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          w = exp_wr[k].pop_front();
          $display("inst%0d write addr=0x%03h data=0x%02h", k, ram_addr[k], ram_wdata[k]);
          chk("wr_addr", k, 64'(ram_addr[k]), 64'(w.addr));
          chk("wr_data", k, 64'(ram_wdata[k]), 64'(w.data));
        end
      end
      if (prev_stall[k])
        chk("stall_hold", k, 64'({ram_we[k], ram_addr[k], ram_wdata[k]}),
            64'({1'b1, prev_addr[k], prev_data[k]}));
      if (done[k] && !done_prev[k]) begin
        if (exp_dn[k].size() == 0) begin
          chk("unexpected_done_cycle", k, 64'(rel_cyc[k]), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          d = exp_dn[k].pop_front();
          $display("inst%0d done cycle=%0d checksum=0x%02h", k, rel_cyc[k], checksum[k]);
          if (d.cyc >= 0) chk("done_cycle", k, 64'(rel_cyc[k]), 64'(d.cyc));
          chk("checksum", k, 64'(checksum[k]), 64'(d.ck));
        end
      end
      prev_stall[k] = ram_we[k] && !ram_ready[k];
      prev_addr[k]  = ram_addr[k];
      prev_data[k]  = ram_wdata[k];
      done_prev[k]  = done[k];
    end
    if (pr_req) chk(pr_nm, pr_k, pack(pr_k) & pr_m, pr_v & pr_m);
    if (fin_req) begin
      for (int k = 0; k < 4; k++) begin
        chk("writes_outstanding", k, 64'(exp_wr[k].size()), 64'd0);
        chk("done_outstanding", k, 64'(exp_dn[k].size()), 64'd0);
        chk("rom_rd_total", k, 64'(rd_cnt[k]), 64'(fin_rd[k]));
      end
    end
  end

  task automatic push_wr(input int k, input logic [11:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr[k].push_back(w);
  endtask

  task automatic push_dn(input int k, input int c, input logic [7:0] ck);
    dn_t d;
    d.cyc = c;
    d.ck  = ck;
    exp_dn[k].push_back(d);
  endtask

  task automatic push_b_run();
    for (int i = 0; i < 4; i++)
      push_wr(1, 12'(32'hFFE + i), 8'(8'h11 * (i + 1)));
    push_dn(1, -1, 8'hAA);
  endtask

  task automatic probe(input int k, input logic [63:0] m, input logic [63:0] v,
                       input string nm);
    pr_k   = k;
    pr_m   = m;
    pr_v   = v;
    pr_nm  = nm;
    pr_req = 1'b1;
    @(negedge clk);
    #1 pr_req = 1'b0;
  endtask

  // kind 0: done; kind 1: rom_rd at address a; kind 2: any rom_rd.
  task automatic wait_for(input int k, input int kind, input logic [11:0] a,
                          input int lim, input string nm);
    bit hit = 1'b0;
    for (int n = 0; n < lim && !hit; n++) begin
      @(posedge clk);
      #1;
      case (kind)
        0:       hit = done[k];
        1:       hit = rom_rd[k] && rom_addr[k] == a;
        default: hit = rom_rd[k];
      endcase
    end
    if (!hit) begin
      tmo_cnt++;
      $display("FAIL timeout %s inst%0d: no event within %0d cycles", nm, k, lim);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst_v[k]   = 1'b1;
      start_v[k] = 1'b0;
    end
    for (int i = 0; i < 4096; i++) push_wr(0, 12'(i), 8'(i));
    push_dn(0, 12289, 8'h00);
    for (int i = 0; i < 8; i++) push_wr(2, 12'(i), 8'(8'h80 + i));
    push_dn(2, 25, 8'h1C);
    push_wr(3, 12'h000, 8'h5A);
    push_dn(3, 4, 8'h5A);

    @(posedge clk);
    #1;
    probe(0, M_OUTS, 64'd0, "reset_outputs");
    probe(1, M_OUTS, 64'd0, "reset_outputs");
    probe(3, M_OUTS, 64'd0, "reset_outputs");
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) rst_v[k] = 1'b0;

    // Reset instance 2 in the READ cycle of word 2, then expect a clean restart.
    wait_for(2, 1, 12'd2, 50, "word2_read");
    rst_v[2] = 1'b1;
    exp_wr[2].delete();
    for (int i = 0; i < 8; i++) push_wr(2, 12'(i), 8'(8'h80 + i));
    @(posedge clk);
    #1 rst_v[2] = 1'b0;
    probe(2, M_OUTS, 64'd0, "rst_abort_outputs");
    wait_for(2, 2, 12'd0, 10, "restart_read");
    probe(2, M_RDADDR, V_RDADDR0, "restart_rom_addr");

    // Manual-start instance: idle without start, stall on word 1, ignored mid-copy start.
    repeat (100) @(posedge clk);
    #1;
    probe(1, M_NOAUTO, 64'd0, "no_autoboot_100");
    push_b_run();
    @(posedge clk);
    #1 start_v[1] = 1'b1;
    @(posedge clk);
    #1 start_v[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1 start_v[1] = 1'b1;
    @(posedge clk);
    #1 start_v[1] = 1'b0;
    wait_for(1, 0, 12'd0, 100, "run1_done");
    probe(1, M_RD, 64'h0004_0000_0000_0000, "rd_count_run1");
    @(posedge clk);
    #1;
    push_b_run();
    start_v[1] = 1'b1;
    @(posedge clk);
    #1 start_v[1] = 1'b0;
    probe(1, M_RESTART, V_RESTART, "restart_clear");
    wait_for(1, 0, 12'd0, 100, "run2_done");

    wait_for(0, 0, 12'd0, 13000, "full_copy_done");

    fin_rd[0] = 4096;
    fin_rd[1] = 8;
    fin_rd[2] = 11;
    fin_rd[3] = 1;
    @(posedge clk);
    #1 fin_req = 1'b1;
    @(negedge clk);
    #1 fin_req = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + tmo_cnt);
    $finish;
  end

endmodule
